// File: rtl/rom_share_arb.sv
// rom_share_arb: shares one synchronous image ROM between the start-screen renderer (port 0)
// and the end-screen renderer (port 1). At most one read is granted per cycle; priority
// follows the game status. Read data is steered back to the requester that issued the read.
module rom_share_arb #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROM_LAT = 1   // legal range 1..3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        game_status,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvld0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvld1,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [DATA_W-1:0] rom_q,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {ModeFix0, ModeFix1, ModeRr} mode_e;

    mode_e               mode;
    logic                last_gnt_q;   // 1 = port 1 granted most recently
    logic                rom_rd_en_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                issue_tag_q;  // port of the read currently at the ROM input
    logic [ROM_LAT-1:0]  pipe_vld_q;
    logic [ROM_LAT-1:0]  pipe_tag_q;
    logic                ret_vld;
    logic                ret_tag;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                rvld0_q;
    logic                rvld1_q;
    logic [15:0]         conflict_cnt_q;
    logic [2:0]          prev_status_q;
    logic                any_gnt;

    // Decode the priority mode; anything that is not START or END falls back to round-robin.
    always_comb begin
        case (game_status)
            3'b001:  mode = ModeFix0;
            3'b100:  mode = ModeFix1;
            default: mode = ModeRr;
        endcase
    end

    // Combinational grant; a lone requester always wins, ties resolved by mode.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                case (mode)
                    ModeFix0: gnt0 = 1'b1;
                    ModeFix1: gnt1 = 1'b1;
                    default: begin
                        if (last_gnt_q) gnt0 = 1'b1;
                        else            gnt1 = 1'b1;
                    end
                endcase
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;

    // Issue stage: register the granted address and remember which port it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q  <= 1'b1;
            rom_rd_en_q <= 1'b0;
            rom_addr_q  <= '0;
            issue_tag_q <= 1'b0;
        end else begin
            rom_rd_en_q <= any_gnt;
            issue_tag_q <= gnt1;
            if (any_gnt) begin
                last_gnt_q <= gnt1;
                rom_addr_q <= gnt0 ? addr0 : addr1;
            end
        end
    end

    // Tag/valid pipeline tracking each read through the ROM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
        end else begin
            pipe_vld_q[0] <= rom_rd_en_q;
            pipe_tag_q[0] <= issue_tag_q;
            for (int i = 1; i < int'(ROM_LAT); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    assign ret_vld = pipe_vld_q[ROM_LAT-1];
    assign ret_tag = pipe_tag_q[ROM_LAT-1];

    // Return stage: capture rom_q into the tagged port and pulse its valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
            rvld0_q  <= 1'b0;
            rvld1_q  <= 1'b0;
        end else begin
            rvld0_q <= ret_vld && !ret_tag;
            rvld1_q <= ret_vld && ret_tag;
            if (ret_vld && !ret_tag) rdata0_q <= rom_q;
            if (ret_vld && ret_tag)  rdata1_q <= rom_q;
        end
    end

    // Contention counter; a status change clears it and wins over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
            prev_status_q  <= 3'b001;
        end else begin
            prev_status_q <= game_status;
            if (game_status != prev_status_q) begin
                conflict_cnt_q <= '0;
            end else if (req0 && req1 && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
        end
    end

    assign rom_addr     = rom_addr_q;
    assign rom_rd_en    = rom_rd_en_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign rvld0        = rvld0_q;
    assign rvld1        = rvld1_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rom_share_arb.sv
// Bench for rom_share_arb: directed request vectors with expected grants; each expected read
// is queued with its data and return cycle, and a monitor checks every rvld pulse against it.
module tb_rom_share_arb;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 8;
    localparam logic [2:0]  ST_START = 3'b001;
    localparam logic [2:0]  ST_PLAY  = 3'b010;
    localparam logic [2:0]  ST_END   = 3'b100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        game_status = ST_START;
    logic              req0 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0;
    logic              gnt0;
    logic [DATA_W-1:0] rdata0;
    logic              rvld0;
    logic              req1 = 1'b0;
    logic [ADDR_W-1:0] addr1 = '0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata1;
    logic              rvld1;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd_en;
    logic [DATA_W-1:0] rom_q = '0;
    logic [15:0]       conflict_cnt;

    rom_share_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .game_status  (game_status),
        .req0         (req0),
        .addr0        (addr0),
        .gnt0         (gnt0),
        .rdata0       (rdata0),
        .rvld0        (rvld0),
        .req1         (req1),
        .addr1        (addr1),
        .gnt1         (gnt1),
        .rdata1       (rdata1),
        .rvld1        (rvld1),
        .rom_addr     (rom_addr),
        .rom_rd_en    (rom_rd_en),
        .rom_q        (rom_q),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
    endfunction

    // One-cycle-latency ROM image.
    always @(posedge clk) if (rom_rd_en) rom_q <= rom_f(rom_addr);

    typedef struct packed {
        logic        port;
        logic [7:0]  data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc      = 0;
    logic        prev_g   = 1'b0;
    logic [13:0] exp_ra   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvld must match the oldest expected read, on time and to the right port.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("rvld_missing", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (rvld0 && rvld1) chk("rvld_both", 32'(rvld1), 32'd0);
            if (rvld0 || rvld1) begin
                if (sb.size() == 0) begin
                    chk("rvld_unexpected", 32'(rvld0 | rvld1), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rvld_port", 32'(rvld1), 32'(e.port));
                    chk("rdata", 32'(rvld1 ? rdata1 : rdata0), 32'(e.data));
                    chk("rvld_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // One cycle of stimulus; entered and left at posedge+1.
    task automatic step(input logic r0, input logic [13:0] a0, input logic r1,
                        input logic [13:0] a1, input logic eg0, input logic eg1);
        exp_t e;
        req0  = r0;
        addr0 = a0;
        req1  = r1;
        addr1 = a1;
        @(negedge clk);
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("rom_rd_en", 32'(rom_rd_en), 32'(prev_g));
        chk("rom_addr", 32'(rom_addr), 32'(exp_ra));
        if (eg0 || eg1) begin
            e.port = eg1;
            e.data = rom_f(eg0 ? a0 : a1);
            e.cyc  = cyc + 3;
            sb.push_back(e);
            exp_ra = eg0 ? a0 : a1;
        end
        prev_g = eg0 | eg1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_rom_rd_en", 32'(rom_rd_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rvld0", 32'(rvld0), 32'd0);
        chk("rst_rvld1", 32'(rvld1), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    endtask

    initial begin
        logic [13:0] a0c;
        logic [13:0] a1c;

        // Reset: grants forced low even with both requests up.
        req0 = 1'b1;
        req1 = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b0;

        // START, port 0 streams 0x10..0x13 back to back.
        for (int i = 0; i < 4; i++) step(1'b1, 14'(16 + i), 1'b0, '0, 1'b1, 1'b0);
        idle(4);
        chk("cnt_single", 32'(conflict_cnt), 32'd0);

        // START contention: port 0 always wins.
        for (int i = 0; i < 3; i++) step(1'b1, 14'(32 + i), 1'b1, 14'h100, 1'b1, 1'b0);
        chk("cnt_start3", 32'(conflict_cnt), 32'd3);
        game_status = ST_END;
        step(1'b1, 14'h023, 1'b1, 14'h100, 1'b0, 1'b1);
        chk("cnt_clear", 32'(conflict_cnt), 32'd0);
        step(1'b1, 14'h023, 1'b1, 14'h101, 1'b0, 1'b1);
        chk("cnt_end1", 32'(conflict_cnt), 32'd1);
        idle(4);

        // PLAY round-robin: port 0 first (port 1 won last), then strict alternation.
        game_status = ST_PLAY;
        idle(1);
        for (int i = 0; i < 6; i++)
            step(1'b1, 14'(48 + (i + 1) / 2), 1'b1, 14'(512 + i / 2),
                 (i % 2) == 0, (i % 2) == 1);
        idle(4);

        // Port 1 read in flight across a switch to START still returns to port 1.
        step(1'b0, '0, 1'b1, 14'h3FFF, 1'b0, 1'b1);
        game_status = ST_START;
        idle(4);

        // Reset one cycle after a grant: nothing may come back.
        step(1'b1, 14'h055, 1'b0, '0, 1'b1, 1'b0);
        rst = 1'b1;
        sb.delete();
        #1;
        chk_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        prev_g = 1'b0;
        exp_ra = '0;
        idle(5);

        // Saturation under sustained PLAY contention.
        game_status = ST_PLAY;
        idle(1);
        a0c = 14'h0;
        a1c = 14'h2000;
        for (int i = 0; i < 65540; i++) begin
            logic g0;
            g0 = (i % 2) == 0;
            step(1'b1, a0c, 1'b1, a1c, g0, !g0);
            if (g0) a0c = a0c + 14'd1;
            else    a1c = a1c + 14'd1;
            if (i == 65533 || i == 65534 || i == 65535 || i == 65539)
                chk("cnt_sat", 32'(conflict_cnt), (i + 1 < 65535) ? 32'(i + 1) : 32'hFFFF);
        end
        idle(5);
        chk("cnt_sat_hold", 32'(conflict_cnt), 32'hFFFF);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
